// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM: sequences fetch, decode, memory, ALU,
// branch and jump steps. A bounded memory wait leads to a sticky TRAP state.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       alu_zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alusrc_a_o,
  output logic [1:0] alusrc_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] state_o,
  output logic       trap_o,
  output logic       retire_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    IMM_EXEC = 4'd10,
    IMM_WB   = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q;
  logic       waiting;
  logic       timeout;

  function automatic logic rtype_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) ||
           (f == 6'h25) || (f == 6'h2A);
  endfunction

  assign timeout = (wait_cnt_q == WAIT_LAST);
  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter restarts on any state change, so it is zero on entry to every wait state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (state_d != state_q) begin
      wait_cnt_q <= '0;
    end else if (waiting && !mem_ready_i) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    waiting      = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alusrc_a_o   = 1'b0;
    alusrc_b_o   = 2'b00;
    alu_op_o     = 3'b000;
    pc_src_o     = 2'b00;
    trap_o       = 1'b0;
    retire_o     = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read_o = 1'b1;
        alusrc_b_o = 2'b01;
        waiting    = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        alusrc_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE:       state_d = rtype_ok(funct_i) ? EXEC : TRAP;
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_ADDI:        state_d = IMM_EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          default:        state_d = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alusrc_a_o = 1'b1;
        alusrc_b_o = 2'b10;
        if (opcode_i == OP_LW) begin
          state_d = MEM_RD;
        end else if (opcode_i == OP_SW) begin
          state_d = MEM_WR;
        end else begin
          state_d = TRAP;
        end
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        waiting    = 1'b1;
        if (mem_ready_i) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_o     = 1'b1;
        state_d      = FETCH;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        waiting     = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = FETCH;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      EXEC: begin
        alusrc_a_o = 1'b1;
        alu_op_o   = 3'b010;
        state_d    = ALU_WB;
      end
      ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      IMM_EXEC: begin
        alusrc_a_o = 1'b1;
        alusrc_b_o = 2'b10;
        state_d    = IMM_WB;
      end
      IMM_WB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alusrc_a_o = 1'b1;
        alu_op_o   = 3'b001;
        pc_src_o   = 2'b01;
        pc_write_o = (opcode_i == OP_BNE) ? ~alu_zero_i : alu_zero_i;
        retire_o   = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
        retire_o   = 1'b1;
        state_d    = FETCH;
      end
      TRAP: begin
        trap_o = 1'b1;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_multi_cycle_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] opcode_i = '0;
  logic [5:0] funct_i = '0;
  logic       alu_zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, alusrc_a_o;
  logic [1:0] alusrc_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       trap_o, retire_o;
  logic [17:0] outv;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .alu_zero_i(alu_zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .iord_o(iord_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alusrc_a_o(alusrc_a_o),
    .alusrc_b_o(alusrc_b_o), .alu_op_o(alu_op_o), .pc_src_o(pc_src_o),
    .state_o(state_o), .trap_o(trap_o), .retire_o(retire_o)
  );

  assign outv = {pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
                 reg_write_o, reg_dst_o, mem_to_reg_o, alusrc_a_o, alusrc_b_o,
                 alu_op_o, pc_src_o, trap_o, retire_o};

  // Per-state output table, packed in the same field order as outv
  function automatic logic [17:0] exp_out(input int st, input logic [5:0] op,
                                          input logic z, input logic rdy);
    logic pcw, irw, mr, mw, io, rw, rd, m2r, asa, tr, ret;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, irw, mr, mw, io, rw, rd, m2r, asa, tr, ret} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin mw = 1; io = 1; ret = rdy; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rw = 1; rd = 1; ret = 1; end
      8:  begin asa = 1; aop = 3'b001; pcs = 2'b01; pcw = (op == 6'h05) ? ~z : z; ret = 1; end
      9:  begin pcs = 2'b10; pcw = 1; ret = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; ret = 1; end
      12: tr = 1;
      default: ;
    endcase
    return {pcw, irw, mr, mw, io, rw, rd, m2r, asa, asb, aop, pcs, tr, ret};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b1;
    mem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy);
    @(negedge clk);
    opcode_i = op; funct_i = fn; alu_zero_i = z; mem_ready_i = rdy;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    tests++;
    if (state_o !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    tests++;
    if (outv !== 18'h08080) begin fails++; $display("FAIL reset_outputs: got %h expected %h", outv, 18'h08080); end
    // Reset while waiting in MEM_RD must also clear the wait counter
    apply_reset();
    drive(6'h23, 6'h00, 1'b0, 1'b1);
    drive(6'h23, 6'h00, 1'b0, 1'b1);
    drive(6'h23, 6'h00, 1'b0, 1'b1);
    drive(6'h23, 6'h00, 1'b0, 1'b0);
    drive(6'h23, 6'h00, 1'b0, 1'b0);
    tests++;
    if (state_o !== 4'd3) begin fails++; $display("FAIL reset_setup_memrd: got %0d expected 3", state_o); end
    apply_reset();
    for (int i = 0; i < TO; i++) begin
      drive(6'h23, 6'h00, 1'b0, 1'b0);
      tests++;
      if (state_o !== 4'd0 || trap_o !== 1'b0) begin
        fails++; $display("FAIL reset_midwait cycle %0d: state %0d trap %b expected 0 0", i, state_o, trap_o);
      end
    end
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    int retires = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(6'h00, 6'h20, 1'b0, 1'b1);
      retires += int'(retire_o);
      tests++;
      if (state_o !== 4'(exp_st[i])) begin
        fails++; $display("FAIL rtype_state cycle %0d: got %0d expected %0d", i, state_o, exp_st[i]);
      end
      tests++;
      if ({reg_write_o, reg_dst_o} !== ((exp_st[i] == 7) ? 2'b11 : 2'b00)) begin
        fails++; $display("FAIL rtype_regctl cycle %0d: got %b%b", i, reg_write_o, reg_dst_o);
      end
    end
    tests++;
    if (retires != 1) begin fails++; $display("FAIL rtype_retire: got %0d expected 1", retires); end
  endtask

  task automatic test_lw_wait();
    int exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(6'h23, 6'h00, 1'b0, !(i >= 3 && i <= 5));
      tests++;
      if (state_o !== 4'(exp_st[i])) begin
        fails++; $display("FAIL lw_state cycle %0d: got %0d expected %0d", i, state_o, exp_st[i]);
      end
      if (i == 7) begin
        tests++;
        if (mem_to_reg_o !== 1'b1 || retire_o !== 1'b1) begin
          fails++; $display("FAIL lw_wb: mem_to_reg %b retire %b expected 1 1", mem_to_reg_o, retire_o);
        end
      end
    end
  endtask

  task automatic test_branch();
    apply_reset();
    drive(6'h04, 6'h00, 1'b0, 1'b1);
    drive(6'h04, 6'h00, 1'b0, 1'b1);
    drive(6'h04, 6'h00, 1'b0, 1'b1);
    tests++;
    if (state_o !== 4'd8 || pc_write_o !== 1'b0 || pc_src_o !== 2'b01 || alu_op_o !== 3'b001) begin
      fails++; $display("FAIL beq: state %0d pc_write %b pc_src %b alu_op %b expected 8 0 01 001",
                        state_o, pc_write_o, pc_src_o, alu_op_o);
    end
    drive(6'h05, 6'h00, 1'b0, 1'b1);
    drive(6'h05, 6'h00, 1'b0, 1'b1);
    drive(6'h05, 6'h00, 1'b0, 1'b1);
    tests++;
    if (state_o !== 4'd8 || pc_write_o !== 1'b1 || retire_o !== 1'b1) begin
      fails++; $display("FAIL bne: state %0d pc_write %b retire %b expected 8 1 1", state_o, pc_write_o, retire_o);
    end
  endtask

  task automatic test_trap();
    apply_reset();
    drive(6'h3F, 6'h00, 1'b0, 1'b1);
    drive(6'h3F, 6'h00, 1'b0, 1'b1);
    tests++;
    if (state_o !== 4'd1) begin fails++; $display("FAIL trap_decode: got %0d expected 1", state_o); end
    for (int i = 0; i < 20; i++) begin
      drive(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
      tests++;
      if (state_o !== 4'd12 || outv !== 18'h00002) begin
        fails++; $display("FAIL trap_hold cycle %0d: state %0d outputs %h expected 12 00002", i, state_o, outv);
      end
    end
    apply_reset();
    drive(6'h00, 6'h00, 1'b0, 1'b0);
    tests++;
    if (state_o !== 4'd0 || trap_o !== 1'b0) begin
      fails++; $display("FAIL trap_reset: state %0d trap %b expected 0 0", state_o, trap_o);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < TO; i++) begin
      drive(6'h00, 6'h20, 1'b0, 1'b0);
      tests++;
      if (state_o !== 4'd0 || ir_write_o !== 1'b0) begin
        fails++; $display("FAIL timeout_wait cycle %0d: state %0d ir_write %b expected 0 0", i, state_o, ir_write_o);
      end
    end
    drive(6'h00, 6'h20, 1'b0, 1'b1);
    tests++;
    if (state_o !== 4'd12 || trap_o !== 1'b1) begin
      fails++; $display("FAIL timeout_trap: state %0d trap %b expected 12 1", state_o, trap_o);
    end
    apply_reset();
    for (int i = 0; i < TO; i++) begin
      drive(6'h00, 6'h20, 1'b0, i == TO - 1);
      tests++;
      if (state_o !== 4'd0) begin fails++; $display("FAIL timeout_ready cycle %0d: got %0d expected 0", i, state_o); end
    end
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    tests++;
    if (state_o !== 4'd1 || trap_o !== 1'b0) begin
      fails++; $display("FAIL timeout_late_ready: state %0d trap %b expected 1 0", state_o, trap_o);
    end
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic z, rdy, trapped;
    int plan[6];
    int n, st, waits;
    logic [5:0] rfuncts[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    apply_reset();
    for (int k = 0; k < 150; k++) begin
      fn = rfuncts[$urandom_range(0, 4)];
      z = 1'($urandom);
      case ($urandom_range(0, 9))
        0, 1: op = 6'h00;
        2:    op = 6'h23;
        3:    op = 6'h2B;
        4:    op = 6'h08;
        5:    op = 6'h04;
        6:    op = 6'h05;
        7:    op = 6'h02;
        8:    op = 6'h3F;
        default: begin op = 6'h00; fn = 6'h03; end
      endcase
      // Instruction-level step list: FETCH, DECODE, then the class-specific steps
      n = 0;
      plan[n++] = 0;
      plan[n++] = 1;
      if (op == 6'h00 && fn != 6'h03) begin plan[n++] = 6; plan[n++] = 7; end
      else if (op == 6'h23) begin plan[n++] = 2; plan[n++] = 3; plan[n++] = 4; end
      else if (op == 6'h2B) begin plan[n++] = 2; plan[n++] = 5; end
      else if (op == 6'h08) begin plan[n++] = 10; plan[n++] = 11; end
      else if (op == 6'h04 || op == 6'h05) plan[n++] = 8;
      else if (op == 6'h02) plan[n++] = 9;
      else plan[n++] = 12;
      trapped = 1'b0;
      st = 0;
      for (int i = 0; i < n; i++) begin
        st = plan[i];
        waits = 0;
        for (int w = 0; w <= TO; w++) begin
          rdy = ($urandom_range(0, 3) != 0);
          drive(op, fn, z, rdy);
          tests++;
          if ({state_o, outv} !== {4'(st), exp_out(st, op, z, rdy)}) begin
            fails++; $display("FAIL random instr %0d op %h: state %0d out %h expected state %0d out %h",
                              k, op, state_o, outv, st, exp_out(st, op, z, rdy));
          end
          if (!(st == 0 || st == 3 || st == 5) || rdy) break;
          waits++;
          if (waits == TO) begin trapped = 1'b1; break; end
        end
        if (trapped || st == 12) break;
      end
      if (trapped) begin
        drive(op, fn, z, 1'b1);
        tests++;
        if (state_o !== 4'd12 || trap_o !== 1'b1) begin
          fails++; $display("FAIL random_timeout instr %0d: state %0d trap %b expected 12 1", k, state_o, trap_o);
        end
      end
      if (trapped || st == 12) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_trap();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum consecutive cycles waited for mem_ready_i in any memory state (legal range 1..255).
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 opcode_i  input  6  instruction bits [31:26], sourced from the instruction register.
REQ-006 funct_i  input  6  instruction bits [5:0]; used only to qualify R-type legality.
REQ-007 alu_zero_i  input  1  ALU zero flag, valid in the BRANCH state.
REQ-008 mem_ready_i  input  1  memory completes the current read/write this cycle.
REQ-009 pc_write_o  output  1  PC load enable.
REQ-010 ir_write_o  output  1  instruction register load enable.
REQ-011 mem_read_o, mem_write_o  output  1 each  memory request strobes.
REQ-012 iord_o  output  1  memory address select: 0 = PC, 1 = ALU out.
REQ-013 reg_write_o, reg_dst_o, mem_to_reg_o  output  1 each  register file controls; reg_dst_o: 1 = rd, 0 = rt.
REQ-014 alusrc_a_o  output  1 (0 = PC, 1 = rs); alusrc_b_o  output  2 (00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2).
REQ-015 alu_op_o  output  3  ALU op class: 000 = add, 001 = sub, 010 = decode funct.
REQ-016 pc_src_o  output  2  PC source: 00 = ALU result, 01 = ALU out register, 10 = jump target.
REQ-017 state_o  output  4  current state encoding; trap_o  output  1  high while in TRAP; retire_o  output  1  one-cycle pulse per completed instruction.

Function
REQ-018 State encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, TRAP=12; codes 13-15 SHALL go to TRAP on the next edge.
REQ-019 FETCH SHALL drive mem_read_o=1, iord_o=0, alusrc_a_o=0, alusrc_b_o=01, alu_op_o=000, and pc_src_o=00.
- ir_write_o and pc_write_o SHALL be high only in the cycle where mem_ready_i=1.
- Then next state SHALL be DECODE.
REQ-020 DECODE SHALL drive alusrc_a_o=0, alusrc_b_o=11, alu_op_o=000 and dispatch on opcode_i:
- 000000 (with funct_i in {20h,22h,24h,25h,2Ah}) -> EXEC.
- 100011, 101011 -> MEM_ADDR.
- 001000 -> IMM_EXEC.
- 000100, 000101 -> BRANCH.
- 000010 -> JUMP.
- anything else -> TRAP.
REQ-021 MEM_ADDR SHALL drive alusrc_a_o=1, alusrc_b_o=10, alu_op_o=000; next state SHALL be MEM_RD for 100011 and MEM_WR for 101011.
REQ-022 MEM_RD SHALL drive mem_read_o=1, iord_o=1, holding until mem_ready_i -> MEM_WB.
REQ-023 MEM_WB SHALL drive reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1 -> FETCH.
REQ-024 MEM_WR SHALL drive mem_write_o=1, iord_o=1, holding until mem_ready_i -> FETCH.
REQ-025 EXEC SHALL drive alusrc_a_o=1, alusrc_b_o=00, alu_op_o=010 -> ALU_WB.
REQ-026 ALU_WB SHALL drive reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0 -> FETCH.
REQ-027 IMM_EXEC SHALL drive alusrc_a_o=1, alusrc_b_o=10, alu_op_o=000 -> IMM_WB.
REQ-028 IMM_WB SHALL drive reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0 -> FETCH.
REQ-029 BRANCH SHALL drive alusrc_a_o=1, alusrc_b_o=00, alu_op_o=001, pc_src_o=01.
- pc_write_o SHALL equal alu_zero_i for 000100 and ~alu_zero_i for 000101.
- Next state SHALL be FETCH.
REQ-030 JUMP SHALL drive pc_src_o=10, pc_write_o=1 -> FETCH.
REQ-031 retire_o SHALL pulse in the final cycle of MEM_WB, MEM_WR (when ready), ALU_WB, IMM_WB, BRANCH and JUMP.
REQ-032 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle mem_ready_i=0.
- If mem_ready_i=0 while the counter equals MEM_TIMEOUT-1, next state SHALL be TRAP.
- mem_ready_i=1 in that same cycle SHALL take priority over the timeout.
REQ-033 TRAP SHALL be sticky until rst_i, with trap_o=1 and every enable/strobe low.
REQ-034 Every output not listed for a state SHALL be 0; mem_ready_i SHALL be ignored outside FETCH, MEM_RD and MEM_WR.
REQ-035 Latency with mem_ready_i=1 on first request SHALL be:
- R-type, sw, addi: 4 cycles.
- lw: 5 cycles.
- beq, bne, j: 3 cycles.

Reset
REQ-036 rst_i=1 at a rising edge SHALL force state FETCH, clear the wait counter, and clear trap, from any state including mid-wait and TRAP.
REQ-037 After reset, all outputs SHALL be 0 except mem_read_o=1, alusrc_b_o=01 and state_o=0.

Verification
REQ-038 R-type add (opcode 00h, funct 20h), ready always 1 -> state sequence 0,1,6,7,0; reg_write_o=1 and reg_dst_o=1 only in state 7; one retire_o pulse.
REQ-039 lw with mem_ready_i low 3 cycles in MEM_RD -> state 3 held 4 cycles, then state 4 with mem_to_reg_o=1; total 8 cycles.
REQ-040 beq with alu_zero_i=0, then bne with alu_zero_i=0 -> pc_write_o=0 in the first BRANCH cycle and 1 in the second.
REQ-041 opcode 3Fh -> TRAP reached from DECODE, trap_o=1 held 20 cycles, then rst_i pulse -> state_o=0, trap_o=0.
REQ-042 MEM_TIMEOUT=4, mem_ready_i=0 in FETCH -> TRAP after exactly 4 FETCH cycles; repeat with ready on the 4th cycle -> DECODE, no trap.
